// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths and register-class helpers used by the writeback path.
package cpu_pkg;

   localparam int REG_ADDR_W    = 5;
   localparam int SCALAR_W      = 32;
   localparam int VEC_W         = 128;
   localparam int WB_FIFO_DEPTH = 4;

   // Vector registers occupy the top quarter of the register address space.
   function automatic logic is_vreg(input logic [REG_ADDR_W-1:0] addr);
      return addr[4:3] == 2'b11;
   endfunction

   function automatic logic same_reg(input logic [REG_ADDR_W-1:0] a,
                                     input logic [REG_ADDR_W-1:0] b);
      return (is_vreg(a) == is_vreg(b)) && (a == b);
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Vector-result queue: circular storage of {addr, data} with count-based full/empty
// and a per-slot valid mask so hazard logic can see every pending destination.
module wb_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = WB_FIFO_DEPTH
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 push,
   input  logic [REG_ADDR_W-1:0]                push_addr,
   input  logic [VEC_W-1:0]                     push_data,
   input  logic                                 pop,
   output logic [REG_ADDR_W-1:0]                head_addr,
   output logic [VEC_W-1:0]                     head_data,
   output logic                                 full,
   output logic                                 empty,
   output logic [DEPTH-1:0][REG_ADDR_W-1:0]     entry_addr,
   output logic [DEPTH-1:0]                     entry_valid
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic [REG_ADDR_W-1:0] addr_mem [DEPTH];
   logic [VEC_W-1:0]      data_mem [DEPTH];
   logic                  do_push;
   logic                  do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign head_addr = addr_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];

   // Pointers are power-of-two wide, so plain increment wraps modulo DEPTH.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         addr_mem[wr_ptr] <= push_addr;
         data_mem[wr_ptr] <= push_data;
      end
   end

   // A slot is live when its distance from the read pointer is below the count.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         entry_addr[i]  = addr_mem[i];
         entry_valid[i] = CW'(PW'(i) - rd_ptr) < count;
      end
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: scalar results win by default, queued vector
// results drain when the scalar side is idle or after three consecutive scalar wins.
module writeback_arbiter
   import cpu_pkg::*;
#(
   parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [REG_ADDR_W-1:0] s_addr,
   input  logic [SCALAR_W-1:0]   s_data,
   input  logic                  v_valid,
   output logic                  v_ready,
   input  logic [REG_ADDR_W-1:0] v_addr,
   input  logic [VEC_W-1:0]      v_data,
   output logic                  we3,
   output logic [REG_ADDR_W-1:0] a3,
   output logic [VEC_W-1:0]      wd3,
   input  logic [REG_ADDR_W-1:0] q_addr1,
   input  logic [REG_ADDR_W-1:0] q_addr2,
   output logic                  q_pend1,
   output logic                  q_pend2
);

   logic                                   empty;
   logic                                   full;
   logic [REG_ADDR_W-1:0]                  head_addr;
   logic [VEC_W-1:0]                       head_data;
   logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0]  entry_addr;
   logic [FIFO_DEPTH-1:0]                  entry_valid;
   logic [1:0]                             starve;
   logic                                   force_pop;
   logic                                   scalar_win;
   logic                                   push;
   logic                                   pop;
   logic [REG_ADDR_W-1:0]                  win_addr;
   logic [VEC_W-1:0]                       win_data;
   logic                                   hit1;
   logic                                   hit2;

   // Handshake: a source transfers only on a cycle where its valid and ready are both
   // high; ready depends on arbiter state alone, never on the same cycle's valid.
   assign force_pop  = !empty && (starve == 2'd3);
   assign s_ready    = rst_n && !force_pop;
   assign v_ready    = rst_n && !full;
   assign scalar_win = s_valid && s_ready;
   assign pop        = !scalar_win && !empty;
   assign push       = v_valid && v_ready;

   wb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (push),
      .push_addr   (v_addr),
      .push_data   (v_data),
      .pop         (pop),
      .head_addr   (head_addr),
      .head_data   (head_data),
      .full        (full),
      .empty       (empty),
      .entry_addr  (entry_addr),
      .entry_valid (entry_valid)
   );

   always_comb begin
      win_addr = head_addr;
      win_data = head_data;
      if (scalar_win) begin
         win_addr = s_addr;
         win_data = {{(VEC_W-SCALAR_W){1'b0}}, s_data};
      end
   end

   // Register 0 is hardwired: its writes are dropped but a3/wd3 still follow the winner.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we3    <= 1'b0;
         a3     <= '0;
         wd3    <= '0;
         starve <= '0;
      end else begin
         if (empty || pop)
            starve <= '0;
         else if (scalar_win)
            starve <= starve + 1'b1;

         if (scalar_win || pop) begin
            we3 <= (win_addr != '0);
            a3  <= win_addr;
            wd3 <= win_data;
         end else begin
            we3 <= 1'b0;
         end
      end
   end

   always_comb begin
      hit1 = we3 && same_reg(a3, q_addr1);
      hit2 = we3 && same_reg(a3, q_addr2);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (entry_valid[i] && same_reg(entry_addr[i], q_addr1)) hit1 = 1'b1;
         if (entry_valid[i] && same_reg(entry_addr[i], q_addr2)) hit2 = 1'b1;
      end
   end

   assign q_pend1 = rst_n && (q_addr1 != '0) && hit1;
   assign q_pend2 = rst_n && (q_addr2 != '0) && hit2;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed and random stimulus for writeback_arbiter with a per-source writeback scoreboard.
module tb_writeback_arbiter;
   import cpu_pkg::*;

   localparam int EW = REG_ADDR_W + VEC_W;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  s_valid;
   logic                  s_ready;
   logic [REG_ADDR_W-1:0] s_addr;
   logic [SCALAR_W-1:0]   s_data;
   logic                  v_valid;
   logic                  v_ready;
   logic [REG_ADDR_W-1:0] v_addr;
   logic [VEC_W-1:0]      v_data;
   logic                  we3;
   logic [REG_ADDR_W-1:0] a3;
   logic [VEC_W-1:0]      wd3;
   logic [REG_ADDR_W-1:0] q_addr1;
   logic [REG_ADDR_W-1:0] q_addr2;
   logic                  q_pend1;
   logic                  q_pend2;

   logic [EW-1:0] s_exp_q[$];
   logic [EW-1:0] v_exp_q[$];
   int checks = 0;
   int errors = 0;

   writeback_arbiter #(.FIFO_DEPTH(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_addr  (s_addr),
      .s_data  (s_data),
      .v_valid (v_valid),
      .v_ready (v_ready),
      .v_addr  (v_addr),
      .v_data  (v_data),
      .we3     (we3),
      .a3      (a3),
      .wd3     (wd3),
      .q_addr1 (q_addr1),
      .q_addr2 (q_addr2),
      .q_pend1 (q_pend1),
      .q_pend2 (q_pend2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [VEC_W-1:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Writes to vector registers come from the vector queue, all others from scalars.
   task automatic monitor();
      logic [EW-1:0] exp;
      if (we3 === 1'b1) begin
         if (is_vreg(a3)) begin
            check("vec_write_expected", EW'(v_exp_q.size() > 0), EW'(1));
            if (v_exp_q.size() > 0) begin
               exp = v_exp_q.pop_front();
               check("vec_write", {a3, wd3}, exp);
            end
         end else begin
            check("scalar_write_expected", EW'(s_exp_q.size() > 0), EW'(1));
            if (s_exp_q.size() > 0) begin
               exp = s_exp_q.pop_front();
               check("scalar_write", {a3, wd3}, exp);
            end
         end
      end
   endtask

   task automatic cycle();
      if (rst_n && s_valid && s_ready && s_addr != '0)
         s_exp_q.push_back({s_addr, {(VEC_W-SCALAR_W){1'b0}}, s_data});
      if (rst_n && v_valid && v_ready && v_addr != '0)
         v_exp_q.push_back({v_addr, v_data});
      @(posedge clk);
      #1;
      monitor();
   endtask

   initial begin
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_addr  = '0;
      s_data  = '0;
      v_valid = 1'b0;
      v_addr  = '0;
      v_data  = '0;
      q_addr1 = 5'd25;
      q_addr2 = 5'd26;

      // Reset state
      cycle();
      cycle();
      check("rst_we3", EW'(we3), EW'(0));
      check("rst_a3", EW'(a3), EW'(0));
      check("rst_wd3", EW'(wd3), EW'(0));
      check("rst_s_ready", EW'(s_ready), EW'(0));
      check("rst_v_ready", EW'(v_ready), EW'(0));
      check("rst_pend1", EW'(q_pend1), EW'(0));
      check("rst_pend2", EW'(q_pend2), EW'(0));
      rst_n   = 1'b1;
      q_addr1 = '0;
      q_addr2 = '0;
      #1;
      check("idle_s_ready", EW'(s_ready), EW'(1));
      check("idle_v_ready", EW'(v_ready), EW'(1));
      cycle();

      // Scalar write, one-cycle latency
      s_valid = 1'b1;
      s_addr  = 5'd5;
      s_data  = 32'hDEADBEEF;
      cycle();
      s_valid = 1'b0;
      check("scalar_we3", EW'(we3), EW'(1));
      check("scalar_a3", EW'(a3), EW'(5));
      check("scalar_wd3", EW'(wd3), EW'(128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF));

      // Vector through an empty queue, two-cycle latency
      v_valid = 1'b1;
      v_addr  = 5'b11010;
      v_data  = 128'h0123456789ABCDEF_FEDCBA9876543210;
      cycle();
      v_valid = 1'b0;
      check("vec_lat_n1_we3", EW'(we3), EW'(0));
      cycle();
      check("vec_lat_we3", EW'(we3), EW'(1));
      check("vec_lat_a3", EW'(a3), EW'(26));
      check("vec_lat_wd3", EW'(wd3), EW'(128'h0123456789ABCDEF_FEDCBA9876543210));

      // Starvation: one queued entry while scalars stream
      s_valid = 1'b1;
      s_addr  = 5'd3;
      s_data  = $urandom;
      v_valid = 1'b1;
      v_addr  = 5'd27;
      v_data  = rand128();
      cycle();
      v_valid = 1'b0;
      q_addr1 = 5'd27;
      q_addr2 = 5'd3;
      #1;
      check("pend_queue_entry", EW'(q_pend1), EW'(1));
      check("pend_write_port", EW'(q_pend2), EW'(1));
      for (int i = 0; i < 4; i++) begin
         check("starve_s_ready", EW'(s_ready), EW'(i == 3 ? 0 : 1));
         s_data = $urandom;
         cycle();
      end
      check("starve_pop_we3", EW'(we3), EW'(1));
      check("starve_pop_a3", EW'(a3), EW'(27));
      check("starve_after_s_ready", EW'(s_ready), EW'(1));
      check("pend_after_pop", EW'(q_pend2), EW'(0));
      s_valid = 1'b0;
      q_addr1 = '0;
      q_addr2 = '0;
      cycle();

      // Full queue with a held fifth vector result
      s_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         v_valid = 1'b1;
         v_addr  = 5'(24 + i);
         v_data  = rand128();
         s_addr  = 5'($urandom_range(1, 23));
         s_data  = $urandom;
         cycle();
      end
      v_addr = 5'd28;
      v_data = rand128();
      s_data = $urandom;
      #1;
      check("full_v_ready", EW'(v_ready), EW'(0));
      check("full_forced_pop", EW'(s_ready), EW'(0));
      cycle();
      check("full_reopen_v_ready", EW'(v_ready), EW'(1));
      s_data = $urandom;
      cycle();
      check("full_refill_v_ready", EW'(v_ready), EW'(0));
      v_valid = 1'b0;
      s_valid = 1'b0;
      repeat (6) cycle();
      check("full_drained_v_ready", EW'(v_ready), EW'(1));

      // Hazard query and address-0 drop
      s_valid = 1'b1;
      s_addr  = 5'd7;
      s_data  = $urandom;
      v_valid = 1'b1;
      v_addr  = 5'd25;
      v_data  = rand128();
      cycle();
      v_valid = 1'b0;
      q_addr1 = 5'd25;
      q_addr2 = 5'd0;
      #1;
      check("hazard_pend1", EW'(q_pend1), EW'(1));
      check("hazard_pend2_zero", EW'(q_pend2), EW'(0));
      q_addr1 = 5'd17;
      q_addr2 = 5'd7;
      #1;
      check("hazard_other_class", EW'(q_pend1), EW'(0));
      check("hazard_write_port", EW'(q_pend2), EW'(1));
      s_addr = 5'd0;
      s_data = $urandom;
      cycle();
      check("drop_scalar_we3", EW'(we3), EW'(0));
      check("drop_scalar_a3", EW'(a3), EW'(0));
      s_valid = 1'b0;
      cycle();
      check("hazard_entry_we3", EW'(we3), EW'(1));
      check("hazard_entry_a3", EW'(a3), EW'(25));
      q_addr1 = '0;
      q_addr2 = '0;
      v_valid = 1'b1;
      v_addr  = 5'd0;
      v_data  = rand128();
      cycle();
      v_valid = 1'b0;
      cycle();
      check("drop_vec_we3", EW'(we3), EW'(0));
      check("drop_vec_a3", EW'(a3), EW'(0));

      // Reset with three queued entries
      s_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         v_valid = 1'b1;
         v_addr  = 5'(29 + i);
         v_data  = rand128();
         s_addr  = 5'($urandom_range(1, 23));
         s_data  = $urandom;
         cycle();
      end
      v_valid = 1'b0;
      s_valid = 1'b0;
      rst_n   = 1'b0;
      q_addr1 = 5'd29;
      #1;
      check("midrst_s_ready", EW'(s_ready), EW'(0));
      check("midrst_v_ready", EW'(v_ready), EW'(0));
      check("midrst_pend1", EW'(q_pend1), EW'(0));
      cycle();
      v_exp_q.delete();
      check("midrst_we3", EW'(we3), EW'(0));
      rst_n = 1'b1;
      cycle();
      check("postrst_v_ready", EW'(v_ready), EW'(1));
      check("postrst_we3", EW'(we3), EW'(0));
      check("postrst_pend1", EW'(q_pend1), EW'(0));
      repeat (4) cycle();
      check("postrst_idle_we3", EW'(we3), EW'(0));
      q_addr1 = '0;

      // Random mixed traffic, then drain
      for (int i = 0; i < 80; i++) begin
         s_valid = 1'($urandom_range(0, 1));
         s_addr  = 5'($urandom_range(0, 23));
         s_data  = $urandom;
         v_valid = 1'($urandom_range(0, 1));
         v_addr  = 5'($urandom_range(24, 31));
         v_data  = rand128();
         cycle();
      end
      s_valid = 1'b0;
      v_valid = 1'b0;
      repeat (8) cycle();
      check("final_scalar_queue_empty", EW'(s_exp_q.size()), EW'(0));
      check("final_vec_queue_empty", EW'(v_exp_q.size()), EW'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning vector-result queue depth (power of two, minimum 2).
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  meaning reset, synchronous and active-low.
REQ-004 SHALL have ports for scalar results:
- s_valid  input  1
- s_ready  output  1
- s_addr  input  5
- s_data  input  32
REQ-005 SHALL have ports for vector/multi-cycle results:
- v_valid  input  1
- v_ready  output  1
- v_addr  input  5
- v_data  input  128
REQ-006 SHALL have register-file write port outputs:
- we3  output  1
- a3  output  5
- wd3  output  128
REQ-007 SHALL have hazard query ports:
- q_addr1  input  5
- q_addr2  input  5
- q_pend1  output  1
- q_pend2  output  1

Function
REQ-008 SHALL transfer a result only on the cycle where valid and ready are both high on that source.
REQ-009 SHALL drive v_ready = 1 exactly when the queue holds fewer than FIFO_DEPTH entries, with no pass-through when full.
REQ-010 SHALL push an accepted vector result {v_addr, v_data} into the queue tail.
REQ-011 SHALL arbitrate each cycle with scalar priority:
- the scalar result is accepted when s_valid and s_ready are high;
- otherwise the queue head pops if the queue is non-empty.
REQ-012 SHALL keep a 2-bit starvation counter:
- increments on each cycle where a scalar wins while the queue is non-empty;
- clears on any pop, and whenever the queue is empty.
REQ-013 SHALL drive s_ready = 0 on the cycle the starvation counter equals 3 with the queue non-empty, forcing a pop; s_ready SHALL be 1 in all other non-reset cycles.
REQ-014 SHALL register the write port with 1-cycle latency:
- winner accepted/popped at cycle N produces we3, a3, wd3 at N+1;
- a vector result pushed into an empty queue at N appears at N+2 at the earliest.
REQ-015 SHALL drive wd3 = {96'b0, s_data} for scalar winners and wd3 = the queue entry data for vector winners.
REQ-016 SHALL drive we3 = 0 on cycles with no winner, and on cycles whose winner address is 0 (the write is dropped); a3 and wd3 still update to the winner's values.
REQ-017 SHALL drop only the entry popped in the current cycle when address 0 is popped; the pop itself still happens.
REQ-018 SHALL keep results in order within the vector source; no ordering is guaranteed between the scalar and vector sources.
REQ-019 SHALL allow a simultaneous push and pop in one cycle on a non-full queue, leaving the count unchanged.
REQ-020 SHALL wrap the read and write pointers modulo FIFO_DEPTH.
REQ-021 SHALL drive q_pendX = 1 combinationally when q_addrX != 0 and q_addrX matches either:
- any valid queue entry address, or
- a3 while we3 = 1.
REQ-022 SHALL treat addresses with [4:3] = 2'b11 as vector-register targets, and all others as scalar targets, for pend matching (full 5-bit compare).

Reset
REQ-023 SHALL, while rst_n = 0 at a clock edge, clear the queue count, the pointers and the starvation counter, and set we3 = 0, a3 = 0, wd3 = 0.
REQ-024 SHALL hold s_ready = 0, v_ready = 0, q_pend1 = 0 and q_pend2 = 0 while rst_n = 0.
REQ-025 SHALL discard queued entries on a reset mid-operation; no write is issued for them afterwards.

Structure
REQ-026 SHALL take REG_ADDR_W = 5, SCALAR_W = 32, VEC_W = 128, WB_FIFO_DEPTH = 4, and an is_vreg(addr) function from the shared package cpu_pkg.
REQ-027 SHALL implement the vector queue as sub-module wb_fifo (storage, pointers, count, full/empty), with arbitration, starvation and pend logic in writeback_arbiter.

Verification
REQ-028 Scalar write: s_valid = 1, s_addr = 5, s_data = 32'hDEADBEEF at cycle N -> at N+1: we3 = 1, a3 = 5, wd3 = 128'h0000_..._DEADBEEF.
REQ-029 Vector latency: v_valid = 1, v_addr = 5'b11010, v_data = 128'h0123... into an empty queue, no scalar, at cycle N -> at N+2: we3 = 1, a3 = 26, wd3 = 128'h0123...
REQ-030 Starvation: queue holds 1 entry and s_valid is held at 1 -> s_ready is low exactly every 4th cycle, and the vector write appears once that cycle has passed.
REQ-031 Full queue: 4 pushes while the scalar source is busy and a 5th v_valid -> v_ready = 0, the 5th result is held, then accepted on the first cycle the queue drops below 4 entries.
REQ-032 Hazard and drop:
- queue holds addr 25 -> q_addr1 = 25 gives q_pend1 = 1, and q_addr2 = 0 gives q_pend2 = 0;
- a scalar write to addr 0 -> we3 stays 0.
REQ-033 Reset with 3 queued entries -> we3 stays 0 and v_ready returns to 1 one cycle after rst_n rises.
